memory_pipe: RTL
================

Name: memory_pipe

Overview:
Parametrised successor to the single-port byte-addressed memory. Byte-array main memory mapped at BASE_ADDR, behind a valid/ready request port and an in-order response port with configurable read latency.
Supports byte/half/word accesses, load sign/zero extension, optional misaligned access, and error reporting for out-of-range or illegal requests.
Sits as the data memory of the single-cycle/pipelined core, and can also serve as the instruction memory (word reads only).

Parameters:
AWIDTH, 32, address width
DWIDTH, 32, data width; fixed at 32
BASE_ADDR, 32'h01000000, byte address of main_memory[0]
MEM_BYTES, 1048576, size of main_memory byte array
READ_LATENCY, 1, cycles from request accept to response; legal 1..4
ALLOW_MISALIGNED, 1, 1 = unaligned half/word allowed (may straddle words); 0 = unaligned flagged as error

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (rst==0 resets)
req_valid_i  input  1  request present
req_ready_o  output  1  request accepted when valid&ready
req_we_i  input  1  1 = store, 0 = load
req_size_i  input  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned_i  input  1  load zero-extends when 1, sign-extends when 0
addr_i  input  AWIDTH  byte address
data_i  input  DWIDTH  store data; low bytes used
rsp_valid_o  output  1  one-cycle response pulse
rsp_data_o  output  DWIDTH  extended load data; 0 for stores and errors
rsp_err_o  output  1  request was illegal; no side effect
busy_o  output  1  at least one request in flight

Behaviour:
- Reset (rst low, asynchronous):
  - req_ready_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, busy_o=0.
  - All pipeline stages invalidated; in-flight responses are dropped, never delivered.
- Memory contents: not reset. Zero-initialised at time 0. Stores committed before reset persist.
- Out of reset: req_ready_o=1 constantly. Throughput is one request per cycle; no backpressure on the response port.
- Access width: N = 1, 2 or 4 bytes; byte offset off = addr_i - BASE_ADDR.
- Error: raised if any of the following holds.
  - addr_i < BASE_ADDR.
  - off+N > MEM_BYTES (32-bit compare, no wrap).
  - req_size_i==11.
  - ALLOW_MISALIGNED=0 with half and addr[0]!=0, or word and addr[1:0]!=0.
- Store, no error: main_memory[off+k] <= data_i[8k+7:8k] for k<N, at the accept edge (little-endian).
- Load, no error:
  - Bytes off..off+N-1 are sampled at the accept edge, little-endian assembled.
  - Then sign- or zero-extended from 8/16 bits; word loads are unchanged.
- Ordering: a load accepted in the cycle after a store to the same bytes returns the new data.
- Response pipeline: a READ_LATENCY-deep shift register of {valid, data, err}.
  - Request accepted at edge t -> rsp_valid_o high during the cycle after edge t+READ_LATENCY-1, for exactly one cycle.
  - Responses are in order. Stores also respond (rsp_data_o=0) so the requester can count completions.
- busy_o = OR of all stage valids.
- Errored request: no memory update; response carries err=1, data=0.
- rsp_data_o and rsp_err_o are 0 whenever rsp_valid_o=0.
- Straddling misaligned access: handled in one cycle (byte array); there is no split state.

Test Plan:
1. After reset, SW 32'hDEADBEEF @BASE+4, then LW @BASE+4 (READ_LATENCY=1) -> store rsp err=0 data=0; load rsp 1 cycle after accept, data=DEADBEEF, err=0.
2. Sign/zero extension after test 1:
   - LB @BASE+7 -> FFFFFFDE; LBU @BASE+7 -> 000000DE.
   - LH @BASE+6 -> FFFFDEAD; LHU @BASE+4 -> 0000BEEF.
3. SB 8'h11 @BASE+5, next cycle LW @BASE+4 -> DEAD11EF (store-to-load forwarding through memory, back-to-back).
4. SW 32'hAABBCCDD @BASE+0x40, then LW @BASE+0x41:
   - ALLOW_MISALIGNED=1 -> 00AABBCC.
   - ALLOW_MISALIGNED=0 -> err=1, data=0, and memory is unchanged.
5. Out-of-range and reserved requests, each must give err=1 with no memory change:
   - LW @BASE-4; SW 32'hFFFFFFFF @BASE+MEM_BYTES-2; size=11 @BASE+0x10.
   - A following LW @BASE+0x10 returns its prior value.
6. READ_LATENCY=3: four back-to-back LWs -> four consecutive rsp_valid cycles, in order, busy_o high throughout.
   - Then pull rst low with 2 requests in flight -> rsp_valid_o=0 and busy_o=0 immediately.
   - No responses after release; previously stored data is still readable.

Source files
------------

// File: rtl/memory_pipe.sv
// Byte-array data/instruction memory behind a valid/ready request port
// with an in-order, fixed-latency response shift register.
module memory_pipe #(
  parameter int                 AWIDTH           = 32,
  parameter int                 DWIDTH           = 32,
  parameter logic [AWIDTH-1:0]  BASE_ADDR        = AWIDTH'(32'h01000000),
  parameter int                 MEM_BYTES        = 1048576,
  parameter int                 READ_LATENCY     = 1,
  parameter int                 ALLOW_MISALIGNED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [AWIDTH-1:0] addr_i,
  input  logic [DWIDTH-1:0] data_i,
  output logic              rsp_valid_o,
  output logic [DWIDTH-1:0] rsp_data_o,
  output logic              rsp_err_o,
  output logic              busy_o
);

  localparam int IW = $clog2(MEM_BYTES);
  localparam int L  = READ_LATENCY;

  logic [7:0] mem [MEM_BYTES];

  logic              ready_q, ready_d;
  logic [L-1:0]      v_q, v_d;
  logic [L-1:0]      e_q, e_d;
  logic [L-1:0][DWIDTH-1:0] d_q, d_d;

  logic              acc;
  logic              mis;
  logic              err;
  logic [3:0]        be;
  logic [AWIDTH-1:0] off;
  logic [AWIDTH:0]   lim;
  logic [IW-1:0]     idx [4];
  logic [31:0]       raw;
  logic [31:0]       ext;

  always_comb begin
    acc = req_valid_i & ready_q;
    off = addr_i - BASE_ADDR;
    case (req_size_i)
      2'b00:   be = 4'b0001;
      2'b01:   be = 4'b0011;
      default: be = 4'b1111;
    endcase
    mis = (req_size_i == 2'b01 && addr_i[0])
       || (req_size_i == 2'b10 && addr_i[1:0] != 2'b00);
    lim = {1'b0, off} + (AWIDTH+1)'(be[3] ? 3'd4 : (be[1] ? 3'd2 : 3'd1));
    // Wide limit compare so an offset near the top cannot wrap past it.
    err = (addr_i < BASE_ADDR)
       || (lim > (AWIDTH+1)'(MEM_BYTES))
       || (req_size_i == 2'b11)
       || (ALLOW_MISALIGNED == 0 && mis);
    raw = '0;
    for (int k = 0; k < 4; k++) begin
      idx[k] = off[IW-1:0] + IW'(k);
      raw[8*k +: 8] = be[k] ? mem[idx[k]] : 8'h00;
    end
    case (req_size_i)
      2'b00:   ext = req_unsigned_i ? {24'h0, raw[7:0]}
                                    : {{24{raw[7]}}, raw[7:0]};
      2'b01:   ext = req_unsigned_i ? {16'h0, raw[15:0]}
                                    : {{16{raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (acc && req_we_i && !err) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[idx[k]] <= data_i[8*k +: 8];
      end
    end
  end

  always_comb begin
    ready_d = 1'b1;
    v_d     = '0;
    e_d     = '0;
    d_d     = '0;
    v_d[0]  = acc;
    e_d[0]  = acc & err;
    d_d[0]  = (acc && !err && !req_we_i) ? DWIDTH'(ext) : '0;
    for (int i = 1; i < L; i++) begin
      v_d[i] = v_q[i-1];
      e_d[i] = e_q[i-1];
      d_d[i] = d_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q <= 1'b0;
      v_q     <= '0;
      e_q     <= '0;
      d_q     <= '0;
    end else begin
      ready_q <= ready_d;
      v_q     <= v_d;
      e_q     <= e_d;
      d_q     <= d_d;
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = v_q[L-1];
  assign rsp_err_o   = e_q[L-1];
  assign rsp_data_o  = d_q[L-1];
  assign busy_o      = |v_q;

endmodule
